pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter XLEN, default 32: PC/datapath width; SHALL be at least 32.
REQ-002 Parameter RESET_VECTOR, default 32'h0040_0000: PC value after reset.
REQ-003 Parameter EXC_VECTOR, default 32'h8000_0180: exception handler entry.
REQ-004 Parameter CNT_W, default 32: width of the retired-update counter.
REQ-005 Ports: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  async active-low reset.
- stall  in  1  hold PC this cycle.
- has_exp  in  1  external exception request.
- exc_code_in  in  5  cause code for has_exp.
- is_eret  in  1  exception return.
- is_jr  in  1  jump-register.
- jump  in  1  J-type jump.
- branch  in  1  conditional branch.
- bne_or_beq  in  1  1=beq, 0=bne.
- equal  in  1  comparator result.
- instr_index  in  26  J-type target field.
- ext_imm  in  XLEN  sign-extended branch offset (words).
- rs_val  in  XLEN  JR target.
- pc  out  XLEN  current PC (registered).
- epc  out  XLEN  exception PC (registered).
- exl  out  1  exception level, 1 = inside handler.
- exc_cause  out  5  last cause code (registered).
- instret  out  CNT_W  count of non-exception PC updates.

Function
REQ-006 pc4 = pc+4 modulo 2^XLEN.
REQ-007 Branch taken = branch & (bne_or_beq XNOR equal); target = pc4 + (ext_imm<<2), truncated to XLEN.
REQ-008 Jump target = {pc4[XLEN-1:28], instr_index, 2'b00}.
REQ-009 Next-PC priority, highest first: exception, eret, jr, jump, taken branch, pc4.
REQ-010 Exception = has_exp, or is_jr selected with rs_val[1:0] != 0 (misaligned target, cause 5'd4).
- has_exp takes precedence; its cause is exc_code_in.
REQ-011 On exception:
- pc <= EXC_VECTOR.
- exc_cause <= cause.
- exl <= 1.
- epc <= current pc only when exl was 0. A nested exception keeps epc but still vectors.
REQ-012 On eret with exl=1: pc <= epc; exl <= 0.
- eret with exl=0: treated as no-op, pc <= pc4.
REQ-013 stall=1 without exception: pc, epc, exl and instret hold; all other controls are ignored.
REQ-014 An exception overrides stall and is taken in the same cycle.
REQ-015 instret increments by 1 on every non-stalled, non-exception update, including eret; it wraps at 2^CNT_W.
REQ-016 Multiple control bits asserted together: only the highest-priority one acts; there is no error.
REQ-017 Latency: control inputs sampled at edge N appear on pc after edge N; no combinational input-to-output path.

Reset
REQ-018 While rst_n=0, regardless of clk:
- pc = RESET_VECTOR.
- epc = 0.
- exl = 0.
- exc_cause = 0.
- instret = 0.
REQ-019 Deassertion is synchronised externally; the first update occurs at the first clk edge after rst_n rises.
REQ-020 Reset asserted mid-handler clears exl and epc immediately.

Structure
REQ-021 Package pc_pkg SHALL hold the cause-code constants (CAUSE_ADEL=5'd4) and the default vector constants.
REQ-022 Sub-module pc_next_sel (combinational target computation and priority mux) SHALL be separate.
- Registers SHALL stay in pc_ctrl.

Verification
REQ-023 Reset, then 3 idle cycles -> pc 0x00400000, 0x00400004, 0x00400008, 0x0040000C; instret=3.
REQ-024 pc=0x00400000, branch=1, bne_or_beq=1, equal=1, ext_imm=4 -> pc=0x00400014.
- Same stimulus with equal=0 -> pc=0x00400004.
REQ-025 Stimuli from pc=0x00400000:
- jump with instr_index=0x0000004 -> pc=0x00000010.
- is_jr with rs_val=0x10000000 -> pc=0x10000000.
- is_jr with rs_val=0x10000002 -> pc=0x80000180, exc_cause=4, epc=0x00400000.
REQ-026 From pc=0x00401234, has_exp with exc_code_in=12 -> pc=0x80000180, epc=0x00401234, exl=1.
- Second has_exp at pc=0x80000180 -> epc stays 0x00401234.
- Then is_eret -> pc=0x00401234, exl=0.
REQ-027 Stall held 2 cycles -> pc and instret unchanged.
- has_exp during stall -> vectors to 0x80000180.
- is_eret with exl=0 -> pc+4.
REQ-028 Preload instret to 2^CNT_W-1 (CNT_W=4 build), then one idle cycle -> instret=0.
- rst_n pulsed low mid-cycle -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and types for the PC controller
package pc_pkg;

    localparam logic [4:0]  CAUSE_NONE           = 5'd0;
    localparam logic [4:0]  CAUSE_ADEL           = 5'd4;

    localparam logic [31:0] DEF_RESET_VECTOR     = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR       = 32'h8000_0180;

    // Next-PC source, listed from lowest to highest priority
    typedef enum logic [2:0] {
        SEL_PC4,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_JR,
        SEL_ERET,
        SEL_EXC
    } sel_e;

    // Taken when the beq/bne polarity matches the comparator result
    function automatic logic branch_taken(input logic branch, input logic bne_or_beq,
                                          input logic equal);
        return branch & ~(bne_or_beq ^ equal);
    endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// rtl/pc_ctrl_if.sv - control inputs and architectural state outputs of the PC controller
interface pc_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             stall;
    logic             has_exp;
    logic [4:0]       exc_code_in;
    logic             is_eret;
    logic             is_jr;
    logic             jump;
    logic             branch;
    logic             bne_or_beq;
    logic             equal;
    logic [25:0]      instr_index;
    logic [XLEN-1:0]  ext_imm;
    logic [XLEN-1:0]  rs_val;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  epc;
    logic             exl;
    logic [4:0]       exc_cause;
    logic [CNT_W-1:0] instret;

    modport master (
        output stall, has_exp, exc_code_in, is_eret, is_jr, jump, branch,
               bne_or_beq, equal, instr_index, ext_imm, rs_val,
        input  pc, epc, exl, exc_cause, instret
    );

    modport slave (
        input  stall, has_exp, exc_code_in, is_eret, is_jr, jump, branch,
               bne_or_beq, equal, instr_index, ext_imm, rs_val,
        output pc, epc, exl, exc_cause, instret
    );
endinterface

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC target computation and priority selection
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  EXC_VECTOR = XLEN'(DEF_EXC_VECTOR)
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] epc,
    input  logic            exl,
    input  logic            stall,
    input  logic            has_exp,
    input  logic [4:0]      exc_code_in,
    input  logic            is_eret,
    input  logic            is_jr,
    input  logic            jump,
    input  logic            branch,
    input  logic            bne_or_beq,
    input  logic            equal,
    input  logic [25:0]     instr_index,
    input  logic [XLEN-1:0] ext_imm,
    input  logic [XLEN-1:0] rs_val,
    output logic [XLEN-1:0] next_pc,
    output logic            take_exc,
    output logic [4:0]      cause,
    output logic            update,
    output logic            eret_ret
);

    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] j_target;
    logic            jr_bad;
    sel_e            sel;

    assign pc4       = pc + XLEN'(4);
    assign br_target = pc4 + (ext_imm << 2);
    assign j_target  = {pc4[XLEN-1:28], instr_index, 2'b00};

    // A jr only counts when eret does not outrank it; a misaligned target then faults
    assign jr_bad    = is_jr & ~is_eret & (rs_val[1:0] != 2'b00);
    assign take_exc  = has_exp | jr_bad;
    assign cause     = has_exp ? exc_code_in : CAUSE_ADEL;

    // Ordinary updates happen only when not stalled and not faulting
    assign update    = ~take_exc & ~stall;
    assign eret_ret  = update & is_eret & exl;

    // Pick the highest-priority source of the next PC
    always_comb begin
        sel = SEL_PC4;
        if (take_exc) begin
            sel = SEL_EXC;
        end else if (is_eret) begin
            sel = SEL_ERET;
        end else if (is_jr) begin
            sel = SEL_JR;
        end else if (jump) begin
            sel = SEL_JUMP;
        end else if (branch_taken(branch, bne_or_beq, equal)) begin
            sel = SEL_BRANCH;
        end
    end

    // Map the selected source to a target address; eret outside a handler just advances
    always_comb begin
        next_pc = pc4;
        case (sel)
            SEL_EXC:    next_pc = EXC_VECTOR;
            SEL_ERET:   next_pc = exl ? epc : pc4;
            SEL_JR:     next_pc = rs_val;
            SEL_JUMP:   next_pc = j_target;
            SEL_BRANCH: next_pc = br_target;
            default:    next_pc = pc4;
        endcase
    end

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - program counter with exception entry/return and retired-update counter
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0]  EXC_VECTOR   = XLEN'(DEF_EXC_VECTOR),
    parameter int               CNT_W        = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    pc_ctrl_if.slave    bus
);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  epc_q;
    logic             exl_q;
    logic [4:0]       cause_q;
    logic [CNT_W-1:0] instret_q;

    logic [XLEN-1:0]  next_pc;
    logic             take_exc;
    logic [4:0]       cause;
    logic             update;
    logic             eret_ret;

    pc_next_sel #(
        .XLEN       (XLEN),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_sel (
        .pc          (pc_q),
        .epc         (epc_q),
        .exl         (exl_q),
        .stall       (bus.stall),
        .has_exp     (bus.has_exp),
        .exc_code_in (bus.exc_code_in),
        .is_eret     (bus.is_eret),
        .is_jr       (bus.is_jr),
        .jump        (bus.jump),
        .branch      (bus.branch),
        .bne_or_beq  (bus.bne_or_beq),
        .equal       (bus.equal),
        .instr_index (bus.instr_index),
        .ext_imm     (bus.ext_imm),
        .rs_val      (bus.rs_val),
        .next_pc     (next_pc),
        .take_exc    (take_exc),
        .cause       (cause),
        .update      (update),
        .eret_ret    (eret_ret)
    );

    // Architectural state: exceptions win over stall; a nested fault keeps the original epc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_VECTOR;
            epc_q     <= '0;
            exl_q     <= 1'b0;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else if (take_exc) begin
            pc_q    <= next_pc;
            cause_q <= cause;
            exl_q   <= 1'b1;
            if (!exl_q) begin
                epc_q <= pc_q;
            end
        end else if (update) begin
            pc_q      <= next_pc;
            instret_q <= instret_q + CNT_W'(1);
            if (eret_ret) begin
                exl_q <= 1'b0;
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.epc       = epc_q;
    assign bus.exl       = exl_q;
    assign bus.exc_cause = cause_q;
    assign bus.instret   = instret_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - self-checking bench for pc_ctrl
module tb_pc_ctrl;

    localparam logic [31:0] RV = 32'h0040_0000;
    localparam logic [31:0] EV = 32'h8000_0180;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_ctrl_if #(.XLEN(32), .CNT_W(32)) bus ();
    pc_ctrl_if #(.XLEN(32), .CNT_W(4))  bus4 ();

    pc_ctrl #(.XLEN(32), .RESET_VECTOR(RV), .EXC_VECTOR(EV), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    pc_ctrl #(.XLEN(32), .RESET_VECTOR(RV), .EXC_VECTOR(EV), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4));

    typedef struct {
        logic        stall, has_exp;
        logic [4:0]  code;
        logic        eret, jr, jump, branch, beq, equal;
        logic [25:0] idx;
        logic [31:0] imm, rs;
    } ctl_t;

    typedef struct {
        string       name;
        ctl_t        c;
        logic [31:0] pc, epc;
        logic        exl;
        logic [4:0]  cause;
        logic [31:0] instret;
    } vec_t;

    int checks = 0;
    int failures = 0;

    longint unsigned m_pc, m_epc, m_instret;
    bit              m_exl;
    logic [4:0]      m_cause;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic ctl_t mkc(input logic stall, input logic has_exp, input logic [4:0] code,
                                 input logic eret, input logic jr, input logic jump,
                                 input logic branch, input logic beq, input logic equal,
                                 input logic [25:0] idx, input logic [31:0] imm,
                                 input logic [31:0] rs);
        ctl_t c;
        c.stall = stall; c.has_exp = has_exp; c.code = code; c.eret = eret; c.jr = jr;
        c.jump = jump; c.branch = branch; c.beq = beq; c.equal = equal;
        c.idx = idx; c.imm = imm; c.rs = rs;
        return c;
    endfunction

    function automatic ctl_t idle();
        return mkc(0, 0, 0, 0, 0, 0, 0, 0, 0, 26'd0, 32'd0, 32'd0);
    endfunction

    task automatic drive(input ctl_t c);
        bus.stall = c.stall; bus.has_exp = c.has_exp; bus.exc_code_in = c.code;
        bus.is_eret = c.eret; bus.is_jr = c.jr; bus.jump = c.jump; bus.branch = c.branch;
        bus.bne_or_beq = c.beq; bus.equal = c.equal; bus.instr_index = c.idx;
        bus.ext_imm = c.imm; bus.rs_val = c.rs;
    endtask

    // Reference: architectural rules applied one instruction at a time
    task automatic model_step(input ctl_t c);
        longint unsigned pc4;
        bit              exc;
        logic [4:0]      cz;
        pc4 = (m_pc + 4) & 64'hFFFF_FFFF;
        exc = 0;
        cz  = 0;
        if (c.has_exp) begin
            exc = 1; cz = c.code;
        end else if (c.jr && !c.eret && (c.rs % 4 != 0)) begin
            exc = 1; cz = 5'd4;
        end
        if (exc) begin
            if (!m_exl) m_epc = m_pc;
            m_pc = EV; m_exl = 1; m_cause = cz;
            return;
        end
        if (c.stall) return;
        m_instret = (m_instret + 1) & 64'hFFFF_FFFF;
        if (c.eret) begin
            if (m_exl) begin
                m_pc = m_epc; m_exl = 0;
            end else begin
                m_pc = pc4;
            end
        end else if (c.jr) begin
            m_pc = c.rs;
        end else if (c.jump) begin
            m_pc = (pc4 & 64'hF000_0000) | (longint'(c.idx) * 4);
        end else if (c.branch && (c.beq == c.equal)) begin
            m_pc = (pc4 + longint'(c.imm) * 4) & 64'hFFFF_FFFF;
        end else begin
            m_pc = pc4;
        end
    endtask

    task automatic do_reset();
        drive(idle());
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_pc = RV; m_epc = 0; m_exl = 0; m_cause = 0; m_instret = 0;
    endtask

    task automatic cycle(input ctl_t c);
        drive(c);
        @(posedge clk);
        #1;
        drive(idle());
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},      64'(bus.pc),        m_pc);
        chk({tag, ".epc"},     64'(bus.epc),       m_epc);
        chk({tag, ".exl"},     64'(bus.exl),       64'(m_exl));
        chk({tag, ".cause"},   64'(bus.exc_cause), 64'(m_cause));
        chk({tag, ".instret"}, 64'(bus.instret),   m_instret);
    endtask

    vec_t vecs[13];

    initial begin
        bus4.stall = 0; bus4.has_exp = 0; bus4.exc_code_in = 0; bus4.is_eret = 0;
        bus4.is_jr = 0; bus4.jump = 0; bus4.branch = 0; bus4.bne_or_beq = 0;
        bus4.equal = 0; bus4.instr_index = 0; bus4.ext_imm = 0; bus4.rs_val = 0;

        //                         stall exp code eret jr jmp br beq eq idx imm rs
        vecs[0]  = '{"beq_taken",   mkc(0,0,0, 0,0,0,1,1,1, 26'd0, 32'd4, 0),          32'h0040_0014, 0, 0, 0, 1};
        vecs[1]  = '{"beq_not",     mkc(0,0,0, 0,0,0,1,1,0, 26'd0, 32'd4, 0),          32'h0040_0004, 0, 0, 0, 1};
        vecs[2]  = '{"bne_back",    mkc(0,0,0, 0,0,0,1,0,0, 26'd0, 32'hFFFF_FFFF, 0), 32'h0040_0000, 0, 0, 0, 1};
        vecs[3]  = '{"jump",        mkc(0,0,0, 0,0,1,0,0,0, 26'd4, 0, 0),              32'h0000_0010, 0, 0, 0, 1};
        vecs[4]  = '{"jr_ok",       mkc(0,0,0, 0,1,0,0,0,0, 26'd0, 0, 32'h1000_0000),  32'h1000_0000, 0, 0, 0, 1};
        vecs[5]  = '{"jr_misalign", mkc(0,0,0, 0,1,0,0,0,0, 26'd0, 0, 32'h1000_0002),  EV, RV, 1, 4, 0};
        vecs[6]  = '{"has_exp",     mkc(0,1,12,0,0,0,0,0,0, 26'd0, 0, 0),              EV, RV, 1, 12, 0};
        vecs[7]  = '{"eret_noexl",  mkc(0,0,0, 1,0,0,0,0,0, 26'd0, 0, 0),              32'h0040_0004, 0, 0, 0, 1};
        vecs[8]  = '{"stall_jump",  mkc(1,0,0, 0,0,1,0,0,0, 26'd4, 0, 0),              RV, 0, 0, 0, 0};
        vecs[9]  = '{"jump_vs_br",  mkc(0,0,0, 0,0,1,1,1,1, 26'd4, 32'd4, 0),          32'h0000_0010, 0, 0, 0, 1};
        vecs[10] = '{"eret_vs_jr",  mkc(0,0,0, 1,1,0,0,0,0, 26'd0, 0, 32'h1000_0002),  32'h0040_0004, 0, 0, 0, 1};
        vecs[11] = '{"exp_stall",   mkc(1,1,3, 0,0,0,0,0,0, 26'd0, 0, 0),              EV, RV, 1, 3, 0};
        vecs[12] = '{"exp_vs_jr",   mkc(0,1,7, 0,1,0,0,0,0, 26'd0, 0, 32'h1000_0001),  EV, RV, 1, 7, 0};

        // Reset values and three idle updates
        do_reset();
        chk("rst.pc", 64'(bus.pc), 64'(RV));
        chk("rst.epc", 64'(bus.epc), 0);
        chk("rst.exl", 64'(bus.exl), 0);
        chk("rst.cause", 64'(bus.exc_cause), 0);
        chk("rst.instret", 64'(bus.instret), 0);
        for (int i = 1; i <= 3; i++) begin
            cycle(idle());
            chk($sformatf("idle%0d.pc", i), 64'(bus.pc), 64'(RV + 32'(4 * i)));
        end
        chk("idle.instret", 64'(bus.instret), 3);

        // Single-step vectors from the reset PC
        foreach (vecs[i]) begin
            do_reset();
            cycle(vecs[i].c);
            chk({vecs[i].name, ".pc"},      64'(bus.pc),        64'(vecs[i].pc));
            chk({vecs[i].name, ".epc"},     64'(bus.epc),       64'(vecs[i].epc));
            chk({vecs[i].name, ".exl"},     64'(bus.exl),       64'(vecs[i].exl));
            chk({vecs[i].name, ".cause"},   64'(bus.exc_cause), 64'(vecs[i].cause));
            chk({vecs[i].name, ".instret"}, 64'(bus.instret),   64'(vecs[i].instret));
        end

        // Nested exception keeps epc, eret returns
        do_reset();
        cycle(mkc(0,0,0, 0,1,0,0,0,0, 26'd0, 0, 32'h0040_1234));
        chk("nest.pre_pc", 64'(bus.pc), 64'h0040_1234);
        cycle(mkc(0,1,12,0,0,0,0,0,0, 26'd0, 0, 0));
        chk("nest.exc1_pc", 64'(bus.pc), 64'(EV));
        chk("nest.exc1_epc", 64'(bus.epc), 64'h0040_1234);
        chk("nest.exc1_exl", 64'(bus.exl), 1);
        cycle(mkc(0,1,1, 0,0,0,0,0,0, 26'd0, 0, 0));
        chk("nest.exc2_pc", 64'(bus.pc), 64'(EV));
        chk("nest.exc2_epc", 64'(bus.epc), 64'h0040_1234);
        chk("nest.exc2_cause", 64'(bus.exc_cause), 1);
        cycle(mkc(0,0,0, 1,0,0,0,0,0, 26'd0, 0, 0));
        chk("nest.eret_pc", 64'(bus.pc), 64'h0040_1234);
        chk("nest.eret_exl", 64'(bus.exl), 0);

        // Stall hold, exception through stall, eret with and without exl
        do_reset();
        cycle(idle());
        for (int i = 0; i < 2; i++) cycle(mkc(1,0,0, 0,0,1,0,0,0, 26'd4, 0, 0));
        chk("stall.pc", 64'(bus.pc), 64'h0040_0004);
        chk("stall.instret", 64'(bus.instret), 1);
        cycle(mkc(1,1,2, 0,0,0,0,0,0, 26'd0, 0, 0));
        chk("stall_exc.pc", 64'(bus.pc), 64'(EV));
        chk("stall_exc.epc", 64'(bus.epc), 64'h0040_0004);
        cycle(mkc(0,0,0, 1,0,0,0,0,0, 26'd0, 0, 0));
        chk("stall_eret.pc", 64'(bus.pc), 64'h0040_0004);
        cycle(mkc(0,0,0, 1,0,0,0,0,0, 26'd0, 0, 0));
        chk("eret_noexl.pc", 64'(bus.pc), 64'h0040_0008);
        chk("eret_noexl.instret", 64'(bus.instret), 3);

        // Counter wrap on the narrow-counter instance
        do_reset();
        repeat (15) cycle(idle());
        chk("wrap.pre", 64'(bus4.instret), 15);
        cycle(idle());
        chk("wrap.post", 64'(bus4.instret), 0);

        // Asynchronous reset in the middle of a handler
        cycle(mkc(0,1,9, 0,0,0,0,0,0, 26'd0, 0, 0));
        chk("async.pre_exl", 64'(bus.exl), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async.pc", 64'(bus.pc), 64'(RV));
        chk("async.epc", 64'(bus.epc), 0);
        chk("async.exl", 64'(bus.exl), 0);
        chk("async.cause", 64'(bus.exc_cause), 0);
        chk("async.instret", 64'(bus.instret), 0);

        // Randomised run against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ctl_t c;
            int   off;
            off = int'($urandom_range(0, 127)) - 64;
            c = mkc(($urandom % 5) == 0, ($urandom % 12) == 0, 5'($urandom),
                    ($urandom % 8) == 0, ($urandom % 6) == 0, ($urandom % 6) == 0,
                    ($urandom % 3) == 0, 1'($urandom), 1'($urandom),
                    26'($urandom), 32'(off),
                    (($urandom % 4) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC));
            drive(c);
            @(posedge clk);
            model_step(c);
            #1;
            check_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
